// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and constants for the PS/2 frame receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_OVR     = 2'b00;
    localparam logic [1:0] ERR_PARITY  = 2'b01;
    localparam logic [1:0] ERR_STOP    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam int FRAME_LEN = 11;

    // Odd parity holds when data plus parity bit contain an odd number of ones.
    function automatic logic parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_clk_filter.sv
`default_nettype none
// ============================================================================
// Module      : ps2_clk_filter
// Description : Synchronizes kbclk/kbdata, glitch-filters kbclk, emits fall.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_clk_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic kbclk,
    input  logic kbdata,
    output logic fall,
    output logic data_s
);

    localparam int c_cnt_w = $clog2(FILTER_LEN) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_filt;
    logic                   r_fall;
    logic                   w_sample;
    logic                   w_flip;

    assign w_sample = r_clk_sync[SYNC_STAGES-1];
    assign w_flip   = (w_sample != r_filt) && (r_cnt == c_cnt_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_cnt      <= '0;
            r_filt     <= 1'b1;
            r_fall     <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], kbclk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], kbdata};
            r_fall     <= w_flip & r_filt;
            if (w_sample == r_filt) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_filt <= ~r_filt;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign fall   = r_fall;
    // Data chain has the same depth as the clock chain and is far inside its hold window.
    assign data_s = r_dat_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx
// Description : PS/2 device-to-host frame receiver (optional PS2_RX_ACK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kbclk,
    input  logic       kbdata,
`ifdef PS2_RX_ACK_EN
    input  logic       ack,
`endif
    output logic [7:0] data,
    output logic       valid,
    output logic       err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int c_data_bits = FRAME_LEN - 3;
    localparam int c_to_w      = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] c_bit_last = 3'(c_data_bits - 1);

    logic w_fall;
    logic w_bit;

    ps2_clk_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_filter (
        .clk    (clk),
        .rst    (rst),
        .kbclk  (kbclk),
        .kbdata (kbdata),
        .fall   (w_fall),
        .data_s (w_bit)
    );

    ps2_state_t       r_state, w_state_nxt;
    logic [2:0]       r_bitcnt, w_bitcnt_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             r_par, w_par_nxt;
    logic [c_to_w-1:0] r_to, w_to_nxt;
    logic [7:0]       r_data, w_data_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_err, w_err_nxt;
    logic [1:0]       r_code, w_code_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_to     <= '0;
            r_data   <= 8'h00;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_code   <= ERR_NONE;
        end else begin
            r_state  <= w_state_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_par    <= w_par_nxt;
            r_to     <= w_to_nxt;
            r_data   <= w_data_nxt;
            r_valid  <= w_valid_nxt;
            r_err    <= w_err_nxt;
            r_code   <= w_code_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_par_nxt    = r_par;
        w_data_nxt   = r_data;
        w_err_nxt    = 1'b0;
        w_code_nxt   = r_code;
`ifdef PS2_RX_ACK_EN
        w_valid_nxt  = r_valid & ~ack;
`else
        w_valid_nxt  = 1'b0;
`endif
        w_to_nxt     = (r_state == IDLE || w_fall) ? '0 : r_to + 1'b1;

        if (w_fall) begin
            case (r_state)
                IDLE: begin
                    if (!w_bit) begin
                        w_state_nxt  = DATA;
                        w_bitcnt_nxt = '0;
                    end
                end
                DATA: begin
                    w_shift_nxt  = {w_bit, r_shift[7:1]};
                    w_bitcnt_nxt = r_bitcnt + 1'b1;
                    if (r_bitcnt == c_bit_last) begin
                        w_state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    w_par_nxt   = w_bit;
                    w_state_nxt = STOP;
                end
                STOP: begin
                    w_state_nxt = IDLE;
                    // A missing stop bit masks any parity verdict.
                    if (!w_bit) begin
                        w_err_nxt  = 1'b1;
                        w_code_nxt = ERR_STOP;
                    end else if (!parity_ok(r_shift, r_par)) begin
                        w_err_nxt  = 1'b1;
                        w_code_nxt = ERR_PARITY;
                    end else begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
`ifdef PS2_RX_ACK_EN
                        if (r_valid && !ack) begin
                            w_err_nxt  = 1'b1;
                            w_code_nxt = ERR_OVR;
                        end
`endif
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end else if (r_state != IDLE && r_to == c_to_last) begin
            w_state_nxt = IDLE;
            w_err_nxt   = 1'b1;
            w_code_nxt  = ERR_TIMEOUT;
        end
    end

    assign data     = r_data;
    assign valid    = r_valid;
    assign err      = r_err;
    assign err_code = r_code;
    assign busy     = (r_state != IDLE);

endmodule
`default_nettype wire
